port_reader: RTL and testbench

- Egress counterpart of the ingress port/controller write path: drains one stored packet from a bank SRAM back onto a 16-bit output port.
- Accepts a packet descriptor (bank, head page, length), walks the page chain via the bank's next-page table, and issues 1-cycle-latency SRAM reads.
- Emits rd_sop/rd_vld/rd_data/rd_eop under downstream backpressure and returns each fully read page to sram_state for reuse.

---
 rtl/hydra_pkg.sv | 18 +
 rtl/port_reader_fifo.sv | 53 +++++
 rtl/port_reader.sv | 187 ++++++++++++++++++
 tb/tb_port_reader.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hydra_pkg.sv
// Shared types and constants for the packet buffer read/write paths.
// Page geometry, bank count, descriptor layout and reader FSM states.
package hydra_pkg;
    localparam int PAGE_WORDS = 8;
    localparam int BANK_NUM   = 32;
    localparam int BANK_W     = 5;
    localparam int LEN_MAX    = 256;
    localparam int PAGE_W_DEF = 11;
    localparam int LEN_W_DEF  = 9;

    typedef enum logic [1:0] {IDLE, SOP, READ, DRAIN} rd_state_e;

    typedef struct packed {
        logic [BANK_W-1:0]     bank;
        logic [PAGE_W_DEF-1:0] page;
        logic [LEN_W_DEF-1:0]  len;
    } pkt_desc_t;
endpackage

// File: rtl/port_reader_fifo.sv
// Output skid FIFO: DEPTH entries, occupancy on count.
// Latency: write visible on pop_dat the cycle after push.
// Backpressure: none internally; the writer must not push when full.
module port_reader_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_vld,
    input  logic [W-1:0]           push_dat,
    input  logic                   pop_rdy,
    output logic [W-1:0]           pop_dat,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_vld) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_rdy)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push_vld, pop_rdy})
            2'b10:   cnt_d = cnt_q + (AW+1)'(1);
            2'b01:   cnt_d = cnt_q - (AW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_vld) mem_q[wr_ptr_q] <= push_dat;
    end

    assign pop_dat = mem_q[rd_ptr_q];
    assign count   = cnt_q;
endmodule

// File: rtl/port_reader.sv
// Egress reader: walks a packet's page chain in bank SRAM and streams it out.
// Latency: rd_sop 1 cycle after descriptor accept, first word 2 cycles after rd_sop.
// Backpressure: out_rdy stalls pops; reads throttle so FIFO + in-flight never overflow.
// Optional PORT_READER_STATS_EN adds pkt_cnt/word_cnt/stall_cnt.
module port_reader
    import hydra_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int PAGE_W     = 11,
    parameter int LEN_W      = 9,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              desc_vld,
    output logic              desc_rdy,
    input  logic [4:0]        desc_bank,
    input  logic [PAGE_W-1:0] desc_page,
    input  logic [LEN_W-1:0]  desc_len,
    output logic              sram_rd_en,
    output logic [4:0]        sram_rd_bank,
    output logic [PAGE_W+2:0] sram_rd_addr,
    input  logic [DATA_W-1:0] sram_dout,
    output logic              nxt_rd_en,
    output logic [PAGE_W-1:0] nxt_rd_addr,
    input  logic [PAGE_W-1:0] nxt_rd_data,
    output logic              free_en,
    output logic [PAGE_W-1:0] free_addr,
    input  logic              out_rdy,
    output logic              rd_sop,
    output logic              rd_vld,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_eop,
    output logic              err_len0
`ifdef PORT_READER_STATS_EN
    ,
    output logic [31:0]       pkt_cnt,
    output logic [31:0]       word_cnt,
    output logic [31:0]       stall_cnt
`endif
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    rd_state_e         state_q, state_d;
    pkt_desc_t         desc_q, desc_d;
    logic [LEN_W-1:0]  issued_q, issued_d, popped_q, popped_d;
    logic [2:0]        off_q, off_d;
    logic [PAGE_W-1:0] page_q, page_d, succ_q, succ_d;
    logic              inflight_q, inflight_d, nxt_pend_q, nxt_pend_d, err_q, err_d;

    logic [DATA_W-1:0] fifo_dat;
    logic [CNT_W-1:0]  fifo_cnt;
    logic              issue, pop, eop, page_end, last_word;
    logic [LEN_W-1:0]  len_m1;

    assign len_m1    = desc_q.len - LEN_W'(1);
    assign issue     = (state_q == SOP || state_q == READ) && (issued_q != desc_q.len) &&
                       ((32'(fifo_cnt) + 32'(inflight_q)) < FIFO_DEPTH);
    assign page_end  = (off_q == 3'(PAGE_WORDS - 1));
    assign last_word = (issued_q == len_m1);
    assign pop       = (state_q == READ || state_q == DRAIN) && (fifo_cnt != '0) && out_rdy;
    assign eop       = pop && (popped_q == len_m1);

    always_comb begin
        state_d    = state_q;
        desc_d     = desc_q;
        issued_d   = issued_q;
        popped_d   = popped_q;
        off_d      = off_q;
        page_d     = page_q;
        succ_d     = succ_q;
        err_d      = 1'b0;
        inflight_d = issue;
        nxt_pend_d = issue && (off_q == 3'd0);

        // Successor lands one cycle after the next-table strobe; used at the page wrap.
        if (nxt_pend_q) succ_d = nxt_rd_data;
        if (issue) begin
            issued_d = issued_q + LEN_W'(1);
            off_d    = off_q + 3'd1;
            if (page_end) page_d = succ_q;
        end
        if (pop) popped_d = popped_q + LEN_W'(1);

        case (state_q)
            IDLE: begin
                if (desc_vld) begin
                    if (desc_len == '0) begin
                        err_d = 1'b1;
                    end else begin
                        desc_d.bank = desc_bank;
                        desc_d.page = desc_page;
                        desc_d.len  = desc_len;
                        issued_d    = '0;
                        popped_d    = '0;
                        off_d       = 3'd0;
                        page_d      = desc_page;
                        state_d     = SOP;
                    end
                end
            end
            SOP:     state_d = READ;
            READ:    if (issued_d == desc_q.len) state_d = DRAIN;
            DRAIN:   if (eop) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            desc_q     <= '0;
            issued_q   <= '0;
            popped_q   <= '0;
            off_q      <= '0;
            page_q     <= '0;
            succ_q     <= '0;
            inflight_q <= 1'b0;
            nxt_pend_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            desc_q     <= desc_d;
            issued_q   <= issued_d;
            popped_q   <= popped_d;
            off_q      <= off_d;
            page_q     <= page_d;
            succ_q     <= succ_d;
            inflight_q <= inflight_d;
            nxt_pend_q <= nxt_pend_d;
            err_q      <= err_d;
        end
    end

    port_reader_fifo #(
        .W     (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_vld (inflight_q),
        .push_dat (sram_dout),
        .pop_rdy  (pop),
        .pop_dat  (fifo_dat),
        .count    (fifo_cnt)
    );

    assign desc_rdy     = (state_q == IDLE);
    assign rd_sop       = (state_q == SOP);
    assign sram_rd_en   = issue;
    assign sram_rd_bank = desc_q.bank;
    assign sram_rd_addr = {page_q, off_q};
    assign nxt_rd_en    = issue && (off_q == 3'd0);
    assign nxt_rd_addr  = page_q;
    assign free_en      = issue && (page_end || last_word);
    assign free_addr    = free_en ? page_q : '0;
    assign rd_vld       = pop;
    assign rd_data      = pop ? fifo_dat : '0;
    assign rd_eop       = eop;
    assign err_len0     = err_q;

`ifdef PORT_READER_STATS_EN
    logic [31:0] pkt_cnt_q, pkt_cnt_d, word_cnt_q, word_cnt_d, stall_cnt_q, stall_cnt_d;

    always_comb begin
        pkt_cnt_d   = pkt_cnt_q + {31'b0, eop};
        word_cnt_d  = word_cnt_q + {31'b0, pop};
        stall_cnt_d = stall_cnt_q + {31'b0, (fifo_cnt != '0) && !out_rdy};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_cnt_q   <= '0;
            word_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            pkt_cnt_q   <= pkt_cnt_d;
            word_cnt_q  <= word_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign pkt_cnt   = pkt_cnt_q;
    assign word_cnt  = word_cnt_q;
    assign stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_port_reader.sv
// Randomized bench for port_reader against a page-chain reference model.
module tb_port_reader;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        desc_vld = 1'b0;
    logic        desc_rdy;
    logic [4:0]  desc_bank = '0;
    logic [10:0] desc_page = '0;
    logic [8:0]  desc_len = '0;
    logic        sram_rd_en;
    logic [4:0]  sram_rd_bank;
    logic [13:0] sram_rd_addr;
    logic [15:0] sram_dout = '0;
    logic        nxt_rd_en;
    logic [10:0] nxt_rd_addr;
    logic [10:0] nxt_rd_data = '0;
    logic        free_en;
    logic [10:0] free_addr;
    logic        out_rdy = 1'b1;
    logic        rd_sop, rd_vld, rd_eop, err_len0;
    logic [15:0] rd_data;
`ifdef PORT_READER_STATS_EN
    logic [31:0] pkt_cnt, word_cnt, stall_cnt;
`endif

    always #5 clk = ~clk;

    port_reader dut (
        .clk(clk), .rst_n(rst_n),
        .desc_vld(desc_vld), .desc_rdy(desc_rdy), .desc_bank(desc_bank),
        .desc_page(desc_page), .desc_len(desc_len),
        .sram_rd_en(sram_rd_en), .sram_rd_bank(sram_rd_bank), .sram_rd_addr(sram_rd_addr),
        .sram_dout(sram_dout), .nxt_rd_en(nxt_rd_en), .nxt_rd_addr(nxt_rd_addr),
        .nxt_rd_data(nxt_rd_data), .free_en(free_en), .free_addr(free_addr),
        .out_rdy(out_rdy), .rd_sop(rd_sop), .rd_vld(rd_vld), .rd_data(rd_data),
        .rd_eop(rd_eop), .err_len0(err_len0)
`ifdef PORT_READER_STATS_EN
        , .pkt_cnt(pkt_cnt), .word_cnt(word_cnt), .stall_cnt(stall_cnt)
`endif
    );

    // Memory models: content is a pure function of (bank, address); next table is an array.
    logic [10:0] nxt_mem [32][2048];

    function automatic logic [15:0] dat_of(input logic [4:0] b, input logic [13:0] a);
        return 16'(({2'b00, a} * 16'h9E37) ^ ({11'b0, b} * 16'h0505) ^ 16'h5A5A);
    endfunction

    always @(posedge clk) begin
        if (sram_rd_en) sram_dout <= dat_of(sram_rd_bank, sram_rd_addr);
        if (nxt_rd_en)  nxt_rd_data <= nxt_mem[sram_rd_bank][nxt_rd_addr];
    end

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Monitor
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [15:0] got_dat[$];
    bit          got_eop[$];
    logic [18:0] got_addr[$];
    logic [10:0] got_free[$];
    int sop_cnt = 0, eop_cnt = 0, err_cnt = 0, order_viol = 0, out_viol = 0, outst = 0;
    int sop_cyc = 0, first_cyc = 0, eop_cyc = 0, rise_cyc = 0, lat_last = 0, sop_gap = 0;
    bit open_pkt = 0, first_seen = 0, rdy_prev = 1;

    always @(negedge clk) begin
        if (!rst_n) begin
            open_pkt = 0;
            outst    = 0;
            rdy_prev = desc_rdy;
        end else begin
            if (rd_sop) begin
                sop_cnt++;
                sop_cyc    = cyc;
                sop_gap    = cyc - rise_cyc;
                open_pkt   = 1;
                first_seen = 0;
            end
            if (sram_rd_en) begin
                got_addr.push_back({sram_rd_bank, sram_rd_addr});
                outst++;
            end
            if (free_en)  got_free.push_back(free_addr);
            if (err_len0) err_cnt++;
            if (rd_eop && !rd_vld) order_viol++;
            if (rd_vld) begin
                if (!open_pkt) order_viol++;
                if (!first_seen) begin
                    first_seen = 1;
                    first_cyc  = cyc;
                    lat_last   = cyc - sop_cyc;
                end
                got_dat.push_back(rd_data);
                got_eop.push_back(rd_eop);
                outst--;
                if (rd_eop) begin
                    eop_cnt++;
                    eop_cyc  = cyc;
                    open_pkt = 0;
                end
            end
            if (outst > 4) out_viol++;
            if (desc_rdy && !rdy_prev) rise_cyc = cyc;
            rdy_prev = desc_rdy;
        end
    end

    // out_rdy pattern: 0 = always ready, 1 = toggle, 2 = random 75%
    int rdy_mode = 0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       out_rdy = 1'b1;
                1:       out_rdy = ~out_rdy;
                default: out_rdy = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Reference model
    logic [15:0] exp_dat[$];
    bit          exp_eop[$];
    logic [18:0] exp_addr[$];
    logic [10:0] exp_free[$];
    int bd, ba, bf, be, bv, bo;

    task automatic begin_test();
        exp_dat.delete(); exp_eop.delete(); exp_addr.delete(); exp_free.delete();
        bd = got_dat.size(); ba = got_addr.size(); bf = got_free.size();
        be = eop_cnt; bv = order_viol; bo = out_viol;
    endtask

    task automatic build_chain(input logic [4:0] b, input logic [10:0] h, input int len);
        logic [10:0] pg, nx;
        pg = h;
        for (int p = 0; p < (len + 7) / 8; p++) begin
            nx = 11'($urandom);
            nxt_mem[b][pg] = nx;
            pg = nx;
        end
    endtask

    task automatic model_pkt(input logic [4:0] b, input logic [10:0] h, input int len);
        logic [10:0] pg;
        logic [13:0] a;
        pg = h;
        for (int i = 0; i < len; i++) begin
            a = {pg, 3'(i % 8)};
            exp_addr.push_back({b, a});
            exp_dat.push_back(dat_of(b, a));
            exp_eop.push_back(i == len - 1);
            if (i % 8 == 7 || i == len - 1) exp_free.push_back(pg);
            if (i % 8 == 7) pg = nxt_mem[b][pg];
        end
    endtask

    task automatic send_desc(input logic [4:0] b, input logic [10:0] p, input logic [8:0] l);
        int k;
        k = 0;
        @(posedge clk);
        #1;
        desc_vld = 1'b1; desc_bank = b; desc_page = p; desc_len = l;
        @(negedge clk);
        while (!desc_rdy && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check("desc_accept", desc_rdy, 1);
        @(posedge clk);
        #1;
        desc_vld = 1'b0;
    endtask

    task automatic wait_eops(input string tag, input int n);
        int k;
        k = 0;
        while (eop_cnt < be + n && k < 5000) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_done"}, eop_cnt - be, n);
        repeat (2) @(negedge clk);
    endtask

    task automatic end_test(input string tag);
        int nm;
        check({tag, "_nwords"}, got_dat.size() - bd, exp_dat.size());
        nm = 0;
        for (int i = 0; i < exp_dat.size() && bd + i < got_dat.size(); i++)
            if (got_dat[bd+i] !== exp_dat[i] || got_eop[bd+i] !== exp_eop[i]) nm++;
        check({tag, "_data_mism"}, nm, 0);
        check({tag, "_nreads"}, got_addr.size() - ba, exp_addr.size());
        nm = 0;
        for (int i = 0; i < exp_addr.size() && ba + i < got_addr.size(); i++)
            if (got_addr[ba+i] !== exp_addr[i]) nm++;
        check({tag, "_addr_mism"}, nm, 0);
        check({tag, "_nfree"}, got_free.size() - bf, exp_free.size());
        nm = 0;
        for (int i = 0; i < exp_free.size() && bf + i < got_free.size(); i++)
            if (got_free[bf+i] !== exp_free[i]) nm++;
        check({tag, "_free_mism"}, nm, 0);
        check({tag, "_order"}, order_viol - bv, 0);
        check({tag, "_overfill"}, out_viol - bo, 0);
    endtask

    task automatic run_one(input string tag, input logic [4:0] b, input logic [10:0] h,
                           input int len, input int mode, input bit chain);
        rdy_mode = mode;
        begin_test();
        if (chain) build_chain(b, h, len);
        model_pkt(b, h, len);
        send_desc(b, h, 9'(len));
        wait_eops(tag, 1);
        end_test(tag);
        if (mode == 0) begin
            check({tag, "_latency"}, (lat_last >= 1 && lat_last <= 2), 1);
            check({tag, "_nobubble"}, eop_cyc - first_cyc, len - 1);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got hang, expected finish");
        $fatal(1);
    end

    initial begin
        int e0, s0, a0, k, len;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ctl", {rd_sop, rd_vld, rd_eop, sram_rd_en, nxt_rd_en, free_en, err_len0}, 0);
        check("rst_desc_rdy", desc_rdy, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        run_one("len5", 5'd3, 11'h010, 5, 0, 1);

        nxt_mem[3][11'h010] = 11'h2A0;
        nxt_mem[3][11'h2A0] = 11'h005;
        nxt_mem[3][11'h005] = 11'h7FF;
        run_one("len20", 5'd3, 11'h010, 20, 0, 0);

        run_one("len16_toggle", 5'd4, 11'h123, 16, 1, 1);

        // Back-to-back: 256-word packet followed immediately by a 1-word packet
        rdy_mode = 0;
        begin_test();
        build_chain(5'd10, 11'h300, 256);
        build_chain(5'd11, 11'h044, 1);
        model_pkt(5'd10, 11'h300, 256);
        model_pkt(5'd11, 11'h044, 1);
        send_desc(5'd10, 11'h300, 9'h100);
        send_desc(5'd11, 11'h044, 9'h001);
        wait_eops("b2b", 2);
        end_test("b2b");
        check("b2b_eop_w256", (got_eop.size() > bd + 255) ? got_eop[bd+255] : 1'b0, 1);
        check("b2b_sop_gap", (sop_gap >= 1 && sop_gap <= 2), 1);

        // Zero-length descriptor
        e0 = err_cnt; s0 = sop_cnt; a0 = got_addr.size();
        send_desc(5'd1, 11'h055, 9'h000);
        repeat (5) @(negedge clk);
        check("len0_err", err_cnt - e0, 1);
        check("len0_nosop", sop_cnt - s0, 0);
        check("len0_noread", got_addr.size() - a0, 0);
        check("len0_rdy", desc_rdy, 1);

        // Reset in the middle of a 20-word packet
        rdy_mode = 0;
        begin_test();
        build_chain(5'd5, 11'h0AB, 20);
        send_desc(5'd5, 11'h0AB, 9'd20);
        k = 0;
        while (got_dat.size() < bd + 7 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("rstmid_reach_w7", got_dat.size() - bd, 7);
        #2;
        rst_n = 1'b0;
        #1;
        check("rstmid_ctl", {rd_sop, rd_vld, rd_eop, sram_rd_en, nxt_rd_en, free_en, err_len0}, 0);
        check("rstmid_bus", (|rd_data) || (|free_addr) || (|sram_rd_addr) || (|sram_rd_bank), 0);
        check("rstmid_rdy", desc_rdy, 1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        run_one("rst_len3", 5'd12, 11'h3C1, 3, 0, 1);

        // Random packets under random backpressure
        for (int n = 0; n < 6; n++) begin
            len = $urandom_range(1, 256);
            run_one($sformatf("rand%0d", n), 5'($urandom), 11'($urandom), len, 2, 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
